// File: rtl/constraint_sweep_ctrl.sv
// rtl/constraint_sweep_ctrl.sv - exhaustive candidate sweep driving one combinational constraint evaluator.
// Optional: SWEEP_EARLY_EXIT_EN stops the sweep at the first satisfying candidate.
module constraint_sweep_ctrl #(
   parameter int VEC_W = 10,
   parameter int CNT_W = VEC_W + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic             sat_in,
   output logic [VEC_W-1:0] cand,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] sat_cnt,
   output logic [VEC_W-1:0] witness,
   output logic             witness_vld,
   output logic             unsat
);

   typedef enum logic [1:0] {ST_IDLE, ST_SWEEP, ST_DONE} state_t;

   localparam logic [VEC_W-1:0] CAND_MAX = '1;

   state_t           state, state_n;
   logic [VEC_W-1:0] cand_n, witness_n;
   logic [CNT_W-1:0] sat_cnt_n;
   logic             witness_vld_n, unsat_n;
   logic             sweep_end;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ST_IDLE;
         cand        <= '0;
         sat_cnt     <= '0;
         witness     <= '0;
         witness_vld <= 1'b0;
         unsat       <= 1'b0;
      end else begin
         state       <= state_n;
         cand        <= cand_n;
         sat_cnt     <= sat_cnt_n;
         witness     <= witness_n;
         witness_vld <= witness_vld_n;
         unsat       <= unsat_n;
      end
   end

   always_comb begin
      state_n       = state;
      cand_n        = cand;
      sat_cnt_n     = sat_cnt;
      witness_n     = witness;
      witness_vld_n = witness_vld;
      unsat_n       = unsat;
      sweep_end     = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) begin
               state_n       = ST_SWEEP;
               cand_n        = '0;
               sat_cnt_n     = '0;
               witness_n     = '0;
               witness_vld_n = 1'b0;
               unsat_n       = 1'b0;
            end
         end
         ST_SWEEP: begin
            // Abort wins over completion and discards this cycle's sample.
            if (abort) begin
               state_n = ST_IDLE;
            end else begin
               if (sat_in) begin
                  sat_cnt_n = sat_cnt + CNT_W'(1);
                  if (!witness_vld) begin
                     witness_n     = cand;
                     witness_vld_n = 1'b1;
                  end
               end
`ifdef SWEEP_EARLY_EXIT_EN
               sweep_end = sat_in || (cand == CAND_MAX);
`else
               sweep_end = (cand == CAND_MAX);
`endif
               if (sweep_end) begin
                  // unsat is registered on DONE entry so it lines up with done.
                  state_n = ST_DONE;
                  unsat_n = (sat_cnt_n == '0);
               end else begin
                  cand_n = cand + VEC_W'(1);
               end
            end
         end
         ST_DONE: begin
            state_n = ST_IDLE;
            unsat_n = (sat_cnt == '0);
         end
         default: state_n = ST_IDLE;
      endcase
   end

   assign busy = (state == ST_SWEEP);
   assign done = (state == ST_DONE);

endmodule

// File: tb/tb_constraint_sweep_ctrl.sv
// tb/tb_constraint_sweep_ctrl.sv - directed self-checking bench for constraint_sweep_ctrl (VEC_W=4).
module tb_constraint_sweep_ctrl;

   localparam int VEC_W = 4;
   localparam int CNT_W = 5;
`ifdef SWEEP_EARLY_EXIT_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst, start, abort, sat_in;
   logic [VEC_W-1:0] cand, witness;
   logic [CNT_W-1:0] sat_cnt;
   logic             busy, done, witness_vld, unsat;

   int mode;
   int n_cmp = 0;
   int n_err = 0;

   int               done_edge;
   logic             done_seen;
   logic [CNT_W-1:0] s_cnt;
   logic [VEC_W-1:0] s_wit, s_cand;
   logic             s_vld, s_unsat;

   constraint_sweep_ctrl #(.VEC_W(VEC_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .sat_in(sat_in),
      .cand(cand), .busy(busy), .done(done), .sat_cnt(sat_cnt),
      .witness(witness), .witness_vld(witness_vld), .unsat(unsat)
   );

   always #5 clk = ~clk;

   always_comb begin
      sat_in = 1'b0;
      case (mode)
         1: sat_in = (cand == 4'd5) || (cand == 4'd9);
         2: sat_in = 1'b1;
         3: sat_in = (cand == 4'd3);
         default: sat_in = 1'b0;
      endcase
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_cand"}, 32'(cand), 0);
      check({tag, "_busy"}, 32'(busy), 0);
      check({tag, "_done"}, 32'(done), 0);
      check({tag, "_cnt"}, 32'(sat_cnt), 0);
      check({tag, "_wit"}, 32'(witness), 0);
      check({tag, "_vld"}, 32'(witness_vld), 0);
      check({tag, "_unsat"}, 32'(unsat), 0);
   endtask

   // Start accepted at edge 0; returns after sampling edge 0.
   task automatic start_sweep();
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic run_to_done();
      done_edge = -1;
      done_seen = 1'b0;
      for (int e = 1; e <= 40; e++) begin
         @(posedge clk);
         #1;
         if (done) begin
            done_edge = e;
            done_seen = 1'b1;
            s_cnt     = sat_cnt;
            s_wit     = witness;
            s_vld     = witness_vld;
            s_unsat   = unsat;
            s_cand    = cand;
            break;
         end
      end
      check("done_within_budget", 32'(done_seen), 1);
   endtask

   task automatic after_done(input string tag);
      @(posedge clk);
      #1;
      check({tag, "_idle_busy"}, 32'(busy), 0);
      check({tag, "_idle_done"}, 32'(done), 0);
      check({tag, "_idle_cand_hold"}, 32'(cand), 32'(s_cand));
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; abort = 1'b0; mode = 0;
      #1;
      check_reset_vals("por");
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Unsatisfiable: never any sat_in
      mode = 0;
      start_sweep();
      run_to_done();
      check("unsat_done_edge", 32'(done_edge), 16);
      check("unsat_cnt", 32'(s_cnt), 0);
      check("unsat_flag", 32'(s_unsat), 1);
      check("unsat_vld", 32'(s_vld), 0);
      check("unsat_cand", 32'(s_cand), 15);
      after_done("unsat");
      check("unsat_flag_hold", 32'(unsat), 1);

      // Two satisfying candidates, 5 and 9
      mode = 1;
      start_sweep();
      run_to_done();
      check("two_done_edge", 32'(done_edge), EARLY ? 6 : 16);
      check("two_cnt", 32'(s_cnt), EARLY ? 1 : 2);
      check("two_wit", 32'(s_wit), 5);
      check("two_vld", 32'(s_vld), 1);
      check("two_unsat", 32'(s_unsat), 0);
      check("two_cand", 32'(s_cand), EARLY ? 5 : 15);
      after_done("two");

      // All satisfying: count reaches 2^VEC_W without overflow
      mode = 2;
      start_sweep();
      run_to_done();
      check("all_done_edge", 32'(done_edge), EARLY ? 1 : 16);
      check("all_cnt", 32'(s_cnt), EARLY ? 1 : 16);
      check("all_wit", 32'(s_wit), 0);
      check("all_cand", 32'(s_cand), EARLY ? 0 : 15);
      check("all_unsat", 32'(s_unsat), 0);
      after_done("all");

      // Abort at edge 8 with sat only at cand 3
      mode = 3;
      start_sweep();
      done_seen = 1'b0;
      for (int e = 1; e <= 7; e++) begin
         @(posedge clk);
         #1;
         if (done) done_seen = 1'b1;
      end
      @(negedge clk);
      abort = 1'b1;
      @(posedge clk);
      #1;
      if (done) done_seen = 1'b1;
      check("abort_busy", 32'(busy), 0);
      check("abort_done_seen", 32'(done_seen), EARLY ? 1 : 0);
      check("abort_cnt", 32'(sat_cnt), 1);
      check("abort_wit", 32'(witness), 3);
      check("abort_vld", 32'(witness_vld), 1);
      @(negedge clk);
      abort = 1'b0;
      start = 1'b1;
      @(posedge clk);
      #1;
      check("restart_busy", 32'(busy), 1);
      check("restart_cand", 32'(cand), 0);
      check("restart_cnt", 32'(sat_cnt), 0);
      check("restart_vld", 32'(witness_vld), 0);
      check("restart_wit", 32'(witness), 0);
      @(negedge clk);
      start = 1'b0;

      // Reset between edges 7 and 8 of the restarted sweep
      mode = 0;
      repeat (7) @(posedge clk);
      #1;
      check("pre_rst_cand", 32'(cand), 7);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check_reset_vals("mid_rst");
      #2;
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("post_rst_busy", 32'(busy), 0);

      // start held during the DONE cycle must not restart
      mode = 0;
      start_sweep();
      run_to_done();
      check("d_done_edge", 32'(done_edge), 16);
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      check("start_in_done_busy", 32'(busy), 0);
      check("start_in_done_done", 32'(done), 0);
      @(negedge clk);
      start = 1'b0;
      @(posedge clk);
      #1;
      check("start_in_done_idle", 32'(busy), 0);
      check("start_in_done_cand", 32'(cand), 15);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
